// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - handshaked word-bus load/store unit with alignment checks and bus timeout
module load_store_unit #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdIn,
    output logic        stall,
    output logic [31:0] readData,
    output logic        misaligned,
    output logic        busError,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [3:0]  memBe,
    output logic [31:0] memWdata,
    input  logic        memReady,
    input  logic [31:0] memRdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic        r_we;
    logic [2:0]  r_size;
    logic [1:0]  r_lane;

    logic        w_illegal;
    logic        w_unaligned;
    logic        w_start;
    logic        w_timeout;
    logic        w_ack;
    logic        w_expire;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_load;

    assign w_illegal   = (size == 3'b011) || (size[2:1] == 2'b11);
    assign w_unaligned = ((size[1:0] == 2'b01) && addr[0]) ||
                         ((size[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    assign w_start     = (r_state == S_IDLE) && req && !w_illegal && !w_unaligned;
    assign w_timeout   = (r_cnt == 8'(MAX_WAIT - 1));
    assign w_ack       = (r_state == S_WAIT) && memReady;
    // memReady in the timeout cycle still counts as a completed access
    assign w_expire    = (r_state == S_WAIT) && !memReady && w_timeout;

    assign misaligned  = (r_state == S_IDLE) && req && (w_illegal || w_unaligned);
    assign stall       = w_start || (r_state == S_WAIT);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdIn;
        case (size[1:0])
            2'b00: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{wdIn[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << addr[1:0];
                w_wdata = {2{wdIn[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_shifted = memRdata >> {r_lane, 3'b000};

    always_comb begin
        w_load = memRdata;
        case (r_size)
            3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_load = {24'd0, w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_load = {16'd0, w_shifted[15:0]};
            default: w_load = memRdata;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_WAIT;
            S_WAIT:  if (w_ack || w_expire) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_cnt    <= 8'd0;
            r_we     <= 1'b0;
            r_size   <= 3'd0;
            r_lane   <= 2'd0;
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= 32'd0;
            memBe    <= 4'd0;
            memWdata <= 32'd0;
            busError <= 1'b0;
            readData <= 32'd0;
        end else begin
            busError <= 1'b0;
            if (w_start) begin
                r_cnt    <= 8'd0;
                r_we     <= we;
                r_size   <= size;
                r_lane   <= addr[1:0];
                memReq   <= 1'b1;
                memWe    <= we;
                memAddr  <= {addr[31:2], 2'b00};
                memBe    <= w_be;
                memWdata <= w_wdata;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 8'd1;
                if (w_ack) begin
                    memReq <= 1'b0;
                    if (!r_we) begin
                        readData <= w_load;
                    end
                end else if (w_expire) begin
                    memReq   <= 1'b0;
                    busError <= 1'b1;
                    readData <= 32'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rstN;
    logic        req;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdIn;
    logic        stall;
    logic [31:0] readData;
    logic        misaligned;
    logic        busError;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [3:0]  memBe;
    logic [31:0] memWdata;
    logic        memReady;
    logic [31:0] memRdata;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_rd = 32'd0;

    load_store_unit #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rstN(rstN), .req(req), .we(we), .size(size), .addr(addr),
        .wdIn(wdIn), .stall(stall), .readData(readData), .misaligned(misaligned),
        .busError(busError), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
        .memBe(memBe), .memWdata(memWdata), .memReady(memReady), .memRdata(memRdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] sz, input logic [1:0] lane,
                                               input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lane +: 8];
        h = (lane >= 2'd2) ? word[31:16] : word[15:0];
        case (sz)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

    task automatic run_access(input string name, input logic w, input logic [2:0] sz,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int delay);
        exp_t        e;
        exp_t        got;
        int          cyc;
        int          wcnt;
        int          exp_stall;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        bit          done;
        if (delay < MAX_WAIT) begin
            e.err = 1'b0;
            if (!w) model_rd = model_load(sz, a[1:0], rd);
            exp_stall = delay + 2;
        end else begin
            e.err = 1'b1;
            model_rd = 32'd0;
            exp_stall = MAX_WAIT + 1;
        end
        e.rd = model_rd;
        sb_q.push_back(e);
        case (sz[1:0])
            2'b00:   begin exp_be = 4'b0001 << a[1:0]; exp_wd = {4{wd[7:0]}};  end
            2'b01:   begin exp_be = 4'b0011 << a[1:0]; exp_wd = {2{wd[15:0]}}; end
            default: begin exp_be = 4'b1111;           exp_wd = wd;            end
        endcase
        req = 1'b1; we = w; size = sz; addr = a; wdIn = wd; memRdata = rd;
        #1;
        check({name, "_stall_c0"}, 32'(stall), 32'd1);
        check({name, "_misaligned"}, 32'(misaligned), 32'd0);
        cyc = 1; wcnt = 0; done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (!stall) begin
                done = 1'b1;
                break;
            end
            cyc++;
            if (wcnt == 0) begin
                check({name, "_memReq"}, 32'(memReq), 32'd1);
                check({name, "_memWe"}, 32'(memWe), 32'(w));
                check({name, "_memAddr"}, memAddr, {a[31:2], 2'b00});
                if (w || sz == 3'b010) check({name, "_memBe"}, 32'(memBe), 32'(exp_be));
                if (w) check({name, "_memWdata"}, memWdata, exp_wd);
            end
            memReady = (wcnt == delay);
            wcnt++;
        end
        memReady = 1'b0;
        req = 1'b0;
        check({name, "_completed"}, 32'(done), 32'd1);
        check({name, "_stall_cycles"}, 32'(cyc), 32'(exp_stall));
        check({name, "_memReq_done"}, 32'(memReq), 32'd0);
        if (sb_q.size() > 0) begin
            got = sb_q.pop_front();
            check({name, "_readData"}, readData, got.rd);
            check({name, "_busError"}, 32'(busError), 32'(got.err));
        end
        @(posedge clk); #1;
        check({name, "_busError_pulse"}, 32'(busError), 32'd0);
    endtask

    task automatic run_bad(input string name, input logic [2:0] sz, input logic [31:0] a);
        req = 1'b1; we = 1'b0; size = sz; addr = a; wdIn = 32'd0;
        #1;
        check({name, "_misaligned"}, 32'(misaligned), 32'd1);
        check({name, "_stall"}, 32'(stall), 32'd0);
        @(posedge clk); #1;
        check({name, "_memReq"}, 32'(memReq), 32'd0);
        check({name, "_still_idle"}, 32'(misaligned), 32'd1);
        req = 1'b0;
        #1;
        check({name, "_misaligned_clr"}, 32'(misaligned), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rstN = 1'b0; req = 1'b0; we = 1'b0; size = 3'd0; addr = 32'd0; wdIn = 32'd0;
        memReady = 1'b0; memRdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_memReq", 32'(memReq), 32'd0);
        check("rst_readData", readData, 32'd0);
        check("rst_busError", 32'(busError), 32'd0);
        check("rst_memAddr", memAddr, 32'd0);
        check("rst_memBe", 32'(memBe), 32'd0);
        check("rst_memWdata", memWdata, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        rstN = 1'b1;
        @(posedge clk); #1;

        run_access("lw100",  1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        run_access("lb103",  1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0);
        run_access("lbu103", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 1);
        run_access("lh102",  1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_0000, 0);
        run_access("lhu102", 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF_0000, 3);
        run_access("lb101",  1'b0, 3'b000, 32'h101, 32'h0, 32'h1234_7F56, 0);
        run_access("sh202",  1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 2);
        run_access("sb201",  1'b1, 3'b000, 32'h201, 32'hCAFE_0055, 32'h0, 1);
        run_access("sw300",  1'b1, 3'b010, 32'h300, 32'hA5A5_1234, 32'h0, 0);

        run_bad("lw101", 3'b010, 32'h101);
        run_bad("sz011", 3'b011, 32'h100);
        run_bad("lh101", 3'b001, 32'h101);
        run_bad("sz111", 3'b111, 32'h100);

        run_access("tmo",      1'b0, 3'b010, 32'h400, 32'h0, 32'h1111_2222, 99);
        run_access("tmo_edge", 1'b0, 3'b010, 32'h400, 32'h0, 32'h3333_4444, MAX_WAIT - 1);

        req = 1'b1; we = 1'b0; size = 3'b010; addr = 32'h500; memReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        check("rstwait_in_wait", 32'(memReq), 32'd1);
        rstN = 1'b0;
        @(posedge clk); #1;
        rstN = 1'b1;
        req = 1'b0;
        #1;
        check("rstwait_memReq", 32'(memReq), 32'd0);
        check("rstwait_busError", 32'(busError), 32'd0);
        check("rstwait_stall", 32'(stall), 32'd0);
        check("rstwait_readData", readData, 32'd0);
        model_rd = 32'd0;
        run_access("lw_after_rst", 1'b0, 3'b010, 32'h504, 32'h0, 32'h0BAD_F00D, 0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory interface between the ALU result and the write-back data select. It turns a load or store request into a handshaked word-bus transaction and stalls the core until the access completes. It formats loaded bytes, halfwords and words into the 32-bit `readData` that write-back consumes. It also detects misaligned and illegal accesses and bus timeouts.

## Interface
- `MAX_WAIT`, 15: WAIT-state cycles without `memReady` before a bus error is flagged (1..255).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rstN`  in  1  reset; synchronous, active-low.
- `req`  in  1  memory instruction in the current cycle; held high by the core while `stall`=1.
- `we`  in  1  1=store, 0=load.
- `size`  in  3  funct3: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu; all other codes are illegal.
- `addr`  in  32  byte address (ALU result).
- `wdIn`  in  32  store data (register rs2).
- `stall`  out  1  freezes the PC and register-file write.
- `readData`  out  32  formatted load result to write-back.
- `misaligned`  out  1  misaligned or illegal access; combinational.
- `busError`  out  1  one-cycle pulse on timeout.
- `memReq`, `memWe`  out  1  bus request and write enable; registered.
- `memAddr`  out  32  word address; `addr` with bits [1:0] forced to 0.
- `memBe`  out  4  byte enables.
- `memWdata`  out  32  store data, replicated across byte lanes.
- `memReady`  in  1  bus done; read data is valid in the same cycle.
- `memRdata`  in  32  bus read word.

## Operation
- The FSM has three states: IDLE, WAIT, DONE.
- IDLE, no `req`: outputs hold; `stall`=0.
- IDLE, `req` with a legal and aligned access:
  - Latch `we`, `size`, `addr[1:0]`.
  - Register `memReq`=1, `memWe`, `memAddr`, `memBe`, `memWdata`.
  - Clear the wait counter and go to WAIT.
- IDLE, `req` with an illegal `size` or a misaligned address:
  - `misaligned`=1 in that cycle, `stall`=0, no bus access.
  - State stays IDLE.
  - Misaligned means a halfword op with `addr[0]`=1, or a word op with `addr[1:0]`≠0.
- WAIT:
  - `memReq` and the bus outputs stay stable.
  - The counter increments every cycle.
  - On `memReady`=1: `memReq`→0; for a load, register the formatted `readData`; go to DONE.
  - If the counter reaches `MAX_WAIT` with no `memReady`: `busError` pulses 1, `readData`←0, `memReq`→0, go to DONE.
  - If `memReady` arrives in the same cycle as the timeout, `memReady` wins and there is no `busError`.
- DONE: `stall`=0 so the core commits the instruction. Go to IDLE unconditionally; `req` is ignored in DONE.
- `stall` = (IDLE & `req` & legal & aligned) | WAIT.
- Store byte enables, with lane = `addr[1:0]`:
  - sb: `memBe` = 0001 << lane.
  - sh: 0011 << lane.
  - sw: 1111.
  - `memWdata` = {4{`wdIn[7:0]`}} for sb, {2{`wdIn[15:0]`}} for sh, `wdIn` for sw.
- Load formatting uses the latched lane:
  - lb/lbu: byte `memRdata[8*lane+7 : 8*lane]`, sign- or zero-extended.
  - lh/lhu: halfword `memRdata[8*lane+15 : 8*lane]`, sign- or zero-extended.
  - lw: the full word.
- A store leaves `readData` unchanged.

## Timing
- Reset (`rstN`=0 at an edge): state IDLE; `memReq`, `memWe`, `busError`, `readData`, `memAddr`, `memBe`, `memWdata` and the counter all go to 0.
- Reset mid-WAIT: `memReq` is 0 after that edge, with no `busError` and no `readData` update.
- Minimum access takes 3 cycles:
  - Cycle 0: IDLE with `req`, `stall`=1.
  - Cycle 1: WAIT with `memReq`=1 and `memReady`=1, `stall`=1.
  - Cycle 2: DONE with `readData` valid and `stall`=0.
- Each extra bus wait cycle adds one stall cycle.
- Timeout path: DONE follows `MAX_WAIT` WAIT cycles; `busError` is high during the first DONE cycle only.
- A back-to-back memory instruction starts in the cycle after DONE.

## Test plan
- lw from 0x100, `memRdata`=0xDEADBEEF, `memReady` in the first WAIT cycle:
  - `memAddr`=0x100, `memBe`=1111.
  - `stall` is high for 2 cycles.
  - `readData`=0xDEADBEEF in DONE.
- lb and lbu from 0x103 with `memRdata`=0x80FF_0000:
  - `memAddr`=0x100.
  - lb gives `readData`=0xFFFFFF80; lbu gives 0x00000080.
- sh to 0x202 with `wdIn`=0x1234ABCD:
  - `memWe`=1, `memAddr`=0x200, `memBe`=1100, `memWdata`=0xABCDABCD.
- lw from 0x101, and `size`=011 at 0x100:
  - `misaligned`=1, `stall`=0.
  - `memReq` never asserts; state stays IDLE.
- `memReady` held 0 with `MAX_WAIT`=15:
  - `busError` pulses once after 15 WAIT cycles.
  - `readData`=0 and `stall` drops.
  - A repeat with `memReady` in exactly that cycle gives no `busError`.
- `rstN`=0 in the third WAIT cycle:
  - `memReq`=0 and state IDLE next cycle.
  - A following lw completes normally.
